reorder_buffer: RTL and testbench

In-order completion tracker that sits directly downstream of middle_end and consumes its completion streams (arith, mem, term ROB entries, valids, term failure and target address).
- Allocates ROB entries to dispatched ops in program order.
- Marks entries done as the pipelines complete them.
- Retires one op per cycle to the committed rename state.
- On a retiring failed terminator, issues a one-cycle pipeline flush with the redirect address.

---
 rtl/reorder_buffer.sv | 129 ++++++++++++
 tb/tb_reorder_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order completion tracker: allocates entries in program order, collects completions and retires one op per cycle.
// A retiring failed terminator squashes every in-flight entry and emits a one-cycle flush pulse carrying its redirect address.
module reorder_buffer #(
  parameter int ROB_AW    = 5,
  parameter int PR_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [7:0]             alloc_arch_dest,
  input  logic [2*PR_ADDR_W-1:0] alloc_phys_dest,
  output logic [ROB_AW-1:0]      alloc_entry,
  input  logic                   complete_arith_valid,
  input  logic [ROB_AW-1:0]      complete_arith_entry,
  input  logic                   complete_mem_valid,
  input  logic [ROB_AW-1:0]      complete_mem_entry,
  input  logic                   complete_term_valid,
  input  logic [ROB_AW-1:0]      complete_term_entry,
  output logic                   complete_term_ready,
  input  logic                   complete_term_failed,
  input  logic [15:0]            term_address,
  output logic                   retire_valid,
  output logic [7:0]             retire_arch_dest,
  output logic [2*PR_ADDR_W-1:0] retire_phys_dest,
  output logic [ROB_AW-1:0]      retire_entry,
  output logic                   flush,
  output logic [15:0]            flush_addr,
  output logic [ROB_AW:0]        count
);
  localparam int DEPTH = 1 << ROB_AW;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state;
  logic [DEPTH-1:0]       valid, done, failed;
  logic [DEPTH-1:0]       valid_nxt, done_nxt, failed_nxt;
  logic [7:0]             arch_mem [DEPTH];
  logic [2*PR_ADDR_W-1:0] phys_mem [DEPTH];
  logic [15:0]            addr_mem [DEPTH];
  logic [ROB_AW-1:0]      head, tail;
  logic [ROB_AW:0]        cnt;
  logic                   run, full, alloc_fire, term_fire, retire_fire, flush_now;

  assign run                 = (state == RUN);
  assign full                = (cnt == (ROB_AW+1)'(DEPTH));
  assign alloc_ready         = !full && run;
  assign alloc_entry         = tail;
  assign count               = cnt;
  assign complete_term_ready = run;
  assign alloc_fire          = alloc_valid && alloc_ready;
  assign term_fire           = complete_term_valid && run && valid[complete_term_entry];
  assign retire_fire         = run && valid[head] && done[head];
  assign flush_now           = retire_fire && failed[head];

  // The allocated index is never valid (not full), so a same-cycle completion to it is dropped by the valid gate.
  always_comb begin
    valid_nxt  = valid;
    done_nxt   = done;
    failed_nxt = failed;
    if (run) begin
      if (complete_arith_valid && valid[complete_arith_entry]) done_nxt[complete_arith_entry] = 1'b1;
      if (complete_mem_valid && valid[complete_mem_entry])     done_nxt[complete_mem_entry]   = 1'b1;
      if (term_fire) begin
        done_nxt[complete_term_entry]   = 1'b1;
        failed_nxt[complete_term_entry] = complete_term_failed;
      end
      if (retire_fire) valid_nxt[head] = 1'b0;
      if (alloc_fire) begin
        valid_nxt[tail]  = 1'b1;
        done_nxt[tail]   = 1'b0;
        failed_nxt[tail] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      head             <= '0;
      tail             <= '0;
      cnt              <= '0;
      valid            <= '0;
      done             <= '0;
      failed           <= '0;
      retire_valid     <= 1'b0;
      retire_arch_dest <= '0;
      retire_phys_dest <= '0;
      retire_entry     <= '0;
      flush            <= 1'b0;
      flush_addr       <= '0;
    end else begin
      retire_valid <= retire_fire;
      flush        <= flush_now;
      if (retire_fire) begin
        retire_arch_dest <= arch_mem[head];
        retire_phys_dest <= phys_mem[head];
        retire_entry     <= head;
      end
      if (flush_now) begin
        flush_addr <= addr_mem[head];
        state      <= FLUSH;
        valid      <= '0;
        done       <= done_nxt;
        failed     <= failed_nxt;
        head       <= '0;
        tail       <= '0;
        cnt        <= '0;
      end else begin
        state  <= RUN;
        valid  <= valid_nxt;
        done   <= done_nxt;
        failed <= failed_nxt;
        if (alloc_fire)  tail <= tail + 1'b1;
        if (retire_fire) head <= head + 1'b1;
        cnt <= cnt + (ROB_AW+1)'(alloc_fire) - (ROB_AW+1)'(retire_fire);
      end
    end
  end

  // Payload storage needs no reset: an entry is only read after allocation has written it.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      arch_mem[tail] <= alloc_arch_dest;
      phys_mem[tail] <= alloc_phys_dest;
    end
    if (term_fire) addr_mem[complete_term_entry] <= term_address;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: table-driven basic flow plus hand-written full/wrap, collision, flush, stray and reset sequences.
module tb_reorder_buffer;
  localparam int AW = 5;
  localparam int PW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid, alloc_ready;
  logic [7:0]      alloc_arch_dest;
  logic [2*PW-1:0] alloc_phys_dest;
  logic [AW-1:0]   alloc_entry;
  logic            complete_arith_valid, complete_mem_valid, complete_term_valid;
  logic [AW-1:0]   complete_arith_entry, complete_mem_entry, complete_term_entry;
  logic            complete_term_ready, complete_term_failed;
  logic [15:0]     term_address;
  logic            retire_valid;
  logic [7:0]      retire_arch_dest;
  logic [2*PW-1:0] retire_phys_dest;
  logic [AW-1:0]   retire_entry;
  logic            flush;
  logic [15:0]     flush_addr;
  logic [AW:0]     count;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_AW(AW), .PR_ADDR_W(PW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_arch_dest(alloc_arch_dest), .alloc_phys_dest(alloc_phys_dest), .alloc_entry(alloc_entry),
    .complete_arith_valid(complete_arith_valid), .complete_arith_entry(complete_arith_entry),
    .complete_mem_valid(complete_mem_valid), .complete_mem_entry(complete_mem_entry),
    .complete_term_valid(complete_term_valid), .complete_term_entry(complete_term_entry),
    .complete_term_ready(complete_term_ready), .complete_term_failed(complete_term_failed),
    .term_address(term_address),
    .retire_valid(retire_valid), .retire_arch_dest(retire_arch_dest),
    .retire_phys_dest(retire_phys_dest), .retire_entry(retire_entry),
    .flush(flush), .flush_addr(flush_addr), .count(count)
  );

  typedef struct packed {
    logic [AW-1:0]   e;
    logic [7:0]      a;
    logic [2*PW-1:0] p;
  } rec_t;

  typedef struct {
    logic          av;
    logic          cav;
    logic [AW-1:0] cae;
    logic          cmv;
    logic [AW-1:0] cme;
    logic          rv;
    logic [AW:0]   cnt;
  } vec_t;

  rec_t          sbq[$];
  vec_t          vt[11];
  int            total = 0;
  int            bad = 0;
  int            seq = 0;
  int            n_retire = 0;
  int            n_before;
  logic [AW-1:0] mtail = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_alloc();
    alloc_valid     = 1'b1;
    alloc_arch_dest = 8'(seq * 37 + 17);
    alloc_phys_dest = 10'(seq * 53 + 9);
    seq++;
  endtask

  // One clock: record accepted allocations, then score retires and flushes seen after the edge.
  task automatic tick();
    rec_t r;
    if (alloc_valid && alloc_ready && !rst) begin
      chk("alloc_entry", 32'(alloc_entry), 32'(mtail));
      sbq.push_back('{e: mtail, a: alloc_arch_dest, p: alloc_phys_dest});
      mtail++;
    end
    @(posedge clk);
    #1;
    alloc_valid          = 1'b0;
    complete_arith_valid = 1'b0;
    complete_mem_valid   = 1'b0;
    complete_term_valid  = 1'b0;
    complete_term_failed = 1'b0;
    if (rst) begin
      sbq.delete();
      mtail = '0;
    end else begin
      if (retire_valid) begin
        n_retire++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL retire_unexpected: entry %0d retired, nothing outstanding", retire_entry);
        end else begin
          r = sbq.pop_front();
          chk("retire_rec", 32'({retire_entry, retire_arch_dest, retire_phys_dest}), 32'(r));
        end
      end
      if (flush) begin
        sbq.delete();
        mtail = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic term(input logic [AW-1:0] e, input logic f, input logic [15:0] a);
    complete_term_valid  = 1'b1;
    complete_term_entry  = e;
    complete_term_failed = f;
    term_address         = a;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_arch_dest = '0; alloc_phys_dest = '0;
    complete_arith_valid = 1'b0; complete_arith_entry = '0;
    complete_mem_valid = 1'b0; complete_mem_entry = '0;
    complete_term_valid = 1'b0; complete_term_entry = '0;
    complete_term_failed = 1'b0; term_address = '0;

    //          av  cav  cae  cmv  cme  rv  cnt
    vt[0]  = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd1};
    vt[1]  = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd2};
    vt[2]  = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd3};
    vt[3]  = '{1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 6'd3};
    vt[4]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd3};
    vt[5]  = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 6'd3};
    vt[6]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd2};
    vt[7]  = '{1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 6'd2};
    vt[8]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd1};
    vt[9]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 6'd0};
    vt[10] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd0};

    do_reset();
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_entry", 32'(alloc_entry), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_retire_valid", 32'(retire_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_term_ready", 32'(complete_term_ready), 1);

    for (int i = 0; i < 11; i++) begin
      if (vt[i].av) set_alloc();
      complete_arith_valid = vt[i].cav;
      complete_arith_entry = vt[i].cae;
      complete_mem_valid   = vt[i].cmv;
      complete_mem_entry   = vt[i].cme;
      tick();
      chk($sformatf("basic%0d_rv", i), 32'(retire_valid), 32'(vt[i].rv));
      chk($sformatf("basic%0d_count", i), 32'(count), 32'(vt[i].cnt));
    end

    // Full and wrap
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_alloc();
      tick();
    end
    chk("full_count", 32'(count), 32);
    chk("full_ready", 32'(alloc_ready), 0);
    set_alloc();
    tick();
    chk("full_hold_count", 32'(count), 32);
    complete_arith_valid = 1'b1; complete_arith_entry = 5'd0;
    tick();
    set_alloc();
    tick();
    chk("full_retire_rv", 32'(retire_valid), 1);
    chk("full_no_bypass_count", 32'(count), 31);
    chk("full_ready_back", 32'(alloc_ready), 1);
    chk("wrap_next_entry", 32'(alloc_entry), 0);
    set_alloc();
    tick();
    chk("wrap_refill_count", 32'(count), 32);
    for (int k = 1; k <= 35; k++) begin
      complete_arith_valid = 1'b1; complete_arith_entry = 5'(k);
      tick();
      tick();
      chk("wrap_rv", 32'(retire_valid), 1);
      set_alloc();
      tick();
      chk("wrap_count", 32'(count), 32);
    end

    // Same-entry completions while alloc and retire coincide
    do_reset();
    set_alloc(); tick();
    set_alloc(); tick();
    complete_arith_valid = 1'b1; complete_arith_entry = 5'd0;
    complete_mem_valid   = 1'b1; complete_mem_entry   = 5'd0;
    tick();
    set_alloc();
    complete_arith_valid = 1'b1; complete_arith_entry = 5'd1;
    complete_mem_valid   = 1'b1; complete_mem_entry   = 5'd1;
    tick();
    chk("sim_rv", 32'(retire_valid), 1);
    chk("sim_entry", 32'(retire_entry), 0);
    chk("sim_count", 32'(count), 2);
    tick();
    chk("sim_rv2", 32'(retire_valid), 1);
    chk("sim_entry2", 32'(retire_entry), 1);
    chk("sim_count2", 32'(count), 1);
    term(5'd2, 1'b0, 16'h1111);
    tick();
    tick();
    chk("sim_rv3", 32'(retire_valid), 1);
    chk("sim_noflush", 32'(flush), 0);
    chk("sim_count3", 32'(count), 0);

    // Failed terminator
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc();
      tick();
    end
    chk("ft_term_ready", 32'(complete_term_ready), 1);
    complete_arith_valid = 1'b1; complete_arith_entry = 5'd0;
    complete_mem_valid   = 1'b1; complete_mem_entry   = 5'd2;
    term(5'd1, 1'b1, 16'hC0DE);
    tick();
    complete_mem_valid = 1'b1; complete_mem_entry = 5'd3;
    tick();
    chk("ft_rv0", 32'(retire_valid), 1);
    chk("ft_entry0", 32'(retire_entry), 0);
    chk("ft_noflush0", 32'(flush), 0);
    chk("ft_count0", 32'(count), 4);
    tick();
    chk("ft_rv1", 32'(retire_valid), 1);
    chk("ft_entry1", 32'(retire_entry), 1);
    chk("ft_flush", 32'(flush), 1);
    chk("ft_flush_addr", 32'(flush_addr), 32'hC0DE);
    chk("ft_count", 32'(count), 0);
    chk("ft_alloc_ready_flush", 32'(alloc_ready), 0);
    chk("ft_term_ready_flush", 32'(complete_term_ready), 0);
    set_alloc();
    tick();
    chk("ft_flush_drop", 32'(flush), 0);
    chk("ft_rv_after", 32'(retire_valid), 0);
    chk("ft_alloc_ready_back", 32'(alloc_ready), 1);
    chk("ft_count_after", 32'(count), 0);
    set_alloc();
    tick();
    chk("ft_realloc_count", 32'(count), 1);
    n_before = n_retire;
    tick();
    tick();
    chk("ft_stale_done_ignored", 32'(n_retire), 32'(n_before));
    complete_arith_valid = 1'b1; complete_arith_entry = 5'd0;
    tick();
    tick();
    chk("ft_realloc_rv", 32'(retire_valid), 1);
    chk("ft_realloc_drain", 32'(count), 0);

    // Stray completion to an unallocated entry
    do_reset();
    complete_mem_valid = 1'b1; complete_mem_entry = 5'd7;
    tick();
    chk("stray_count", 32'(count), 0);
    chk("stray_rv", 32'(retire_valid), 0);
    for (int i = 0; i < 8; i++) begin
      set_alloc();
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      complete_arith_valid = 1'b1; complete_arith_entry = 5'(i);
      tick();
    end
    tick();
    tick();
    chk("stray_hold_count", 32'(count), 1);
    chk("stray_hold_rv", 32'(retire_valid), 0);
    complete_arith_valid = 1'b1; complete_arith_entry = 5'd7;
    tick();
    tick();
    chk("stray_rv7", 32'(retire_valid), 1);
    chk("stray_entry7", 32'(retire_entry), 7);
    chk("stray_drain", 32'(count), 0);
    chk("stray_sb_empty", 32'(sbq.size()), 0);

    // Reset while a flush is about to fire
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_alloc();
      tick();
    end
    term(5'd0, 1'b1, 16'h1234);
    tick();
    chk("mid_count_pre", 32'(count), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rv", 32'(retire_valid), 0);
    chk("mid_flush", 32'(flush), 0);
    chk("mid_flush_addr", 32'(flush_addr), 0);
    chk("mid_count", 32'(count), 0);
    chk("mid_alloc_ready", 32'(alloc_ready), 1);
    chk("mid_alloc_entry", 32'(alloc_entry), 0);
    chk("mid_retire_data", 32'({retire_entry, retire_arch_dest, retire_phys_dest}), 0);
    chk("mid_term_ready", 32'(complete_term_ready), 1);
    n_before = n_retire;
    tick();
    tick();
    chk("mid_no_retire", 32'(n_retire), 32'(n_before));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
